// File: rtl/mul_writeback_ctrl.sv
// mul_writeback_ctrl: sequences one 16x16 multiply and writes the product
// back to the register file one word per beat through a granted write port.
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   i_start                  issue op (taken only when idle)
//   i_op_a, i_op_b           unsigned operands
//   i_rd_lo, i_rd_hi         destinations of low / high product word
//   o_busy                   op in flight
//   o_mul_a, o_mul_b         registered operands to external multiplier
//   i_mul_lo, i_mul_hi       multiplier product words
//   o_wr_req, i_wr_gnt       write handshake (commit on req & gnt)
//   o_wr_addr, o_wr_data     write address / data, valid with o_wr_req
//   o_done                   one-cycle pulse after the final write commits
//   o_ovf, o_zero            product flags, updated at end of CALC
//   o_stall_cnt              saturating count of req & !gnt cycles
module mul_writeback_ctrl #(
   parameter int DATA_W   = 16,
   parameter int REG_AW   = 3,
   parameter int WRITE_HI = 1,
   parameter int STALL_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_op_a,
   input  logic [DATA_W-1:0] i_op_b,
   input  logic [REG_AW-1:0] i_rd_lo,
   input  logic [REG_AW-1:0] i_rd_hi,
   output logic              o_busy,
   output logic [DATA_W-1:0] o_mul_a,
   output logic [DATA_W-1:0] o_mul_b,
   input  logic [DATA_W-1:0] i_mul_lo,
   input  logic [DATA_W-1:0] i_mul_hi,
   output logic              o_wr_req,
   input  logic              i_wr_gnt,
   output logic [REG_AW-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   output logic              o_done,
   output logic              o_ovf,
   output logic              o_zero,
   output logic [STALL_W-1:0] o_stall_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_WR_LO = 2'd2,
      S_WR_HI = 2'd3
   } state_t;

   localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

   state_t                r_state;
   state_t                w_next;

   logic [DATA_W-1:0]     r_mul_a;
   logic [DATA_W-1:0]     r_mul_b;
   logic [REG_AW-1:0]     r_rd_lo;
   logic [REG_AW-1:0]     r_rd_hi;
   logic [2*DATA_W-1:0]   r_prod;
   logic                  r_ovf;
   logic                  r_zero;
   logic                  r_done;
   logic [STALL_W-1:0]    r_stall;

   logic                  w_accept;
   logic                  w_capture;
   logic                  w_busy;
   logic                  w_wr_req;
   logic [REG_AW-1:0]     w_wr_addr;
   logic [DATA_W-1:0]     w_wr_data;
   logic                  w_last_gnt;
   logic                  w_stall;
   logic [2*DATA_W-1:0]   w_prod;

   assign w_prod = {i_mul_hi, i_mul_lo};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next = S_CALC;
         end
         S_CALC: begin
            w_next = S_WR_LO;
         end
         S_WR_LO: begin
            if (i_wr_gnt) begin
               w_next = (WRITE_HI != 0) ? S_WR_HI : S_IDLE;
            end
         end
         S_WR_HI: begin
            if (i_wr_gnt) w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Output / control decode
   always_comb begin
      w_busy     = 1'b1;
      w_accept   = 1'b0;
      w_capture  = 1'b0;
      w_wr_req   = 1'b0;
      w_wr_addr  = '0;
      w_wr_data  = '0;
      w_last_gnt = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy   = 1'b0;
            w_accept = i_start;
         end
         S_CALC: begin
            w_capture = 1'b1;
         end
         S_WR_LO: begin
            w_wr_req   = 1'b1;
            w_wr_addr  = r_rd_lo;
            w_wr_data  = r_prod[DATA_W-1:0];
            w_last_gnt = i_wr_gnt && (WRITE_HI == 0);
         end
         S_WR_HI: begin
            w_wr_req   = 1'b1;
            w_wr_addr  = r_rd_hi;
            w_wr_data  = r_prod[2*DATA_W-1:DATA_W];
            w_last_gnt = i_wr_gnt;
         end
         default: begin
            w_busy = 1'b0;
         end
      endcase
   end

   assign w_stall = w_wr_req & ~i_wr_gnt;

   // Operand / destination latch on accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mul_a <= '0;
         r_mul_b <= '0;
         r_rd_lo <= '0;
         r_rd_hi <= '0;
      end else if (w_accept) begin
         r_mul_a <= i_op_a;
         r_mul_b <= i_op_b;
         r_rd_lo <= i_rd_lo;
         r_rd_hi <= i_rd_hi;
      end
   end

   // Product capture and flags; flags persist until the next CALC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod <= '0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
      end else if (w_capture) begin
         r_prod <= w_prod;
         r_ovf  <= (i_mul_hi != '0);
         r_zero <= (w_prod == '0);
      end
   end

   // Grant-stall counter: cleared on accept, saturates at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall <= '0;
      end else if (w_accept) begin
         r_stall <= '0;
      end else if (w_stall && (r_stall != STALL_MAX)) begin
         r_stall <= r_stall + 1'b1;
      end
   end

   // done lands in the first IDLE cycle after the final commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_last_gnt;
      end
   end

   assign o_busy      = w_busy;
   assign o_mul_a     = r_mul_a;
   assign o_mul_b     = r_mul_b;
   assign o_wr_req    = w_wr_req;
   assign o_wr_addr   = w_wr_addr;
   assign o_wr_data   = w_wr_data;
   assign o_done      = r_done;
   assign o_ovf       = r_ovf;
   assign o_zero      = r_zero;
   assign o_stall_cnt = r_stall;

endmodule

// File: tb/tb_mul_writeback_ctrl.sv
// tb_mul_writeback_ctrl: scoreboard bench for mul_writeback_ctrl with a
// behavioural multiply model; second instance covers the low-word-only build.
module tb_mul_writeback_ctrl;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int SW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Main instance (low then high word)
   logic          start;
   logic [DW-1:0] op_a, op_b;
   logic [AW-1:0] rd_lo, rd_hi;
   logic          busy;
   logic [DW-1:0] mul_a, mul_b, mul_lo, mul_hi;
   logic          wr_req, wr_gnt;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          done, ovf, zero;
   logic [SW-1:0] stall_cnt;
   logic [31:0]   prod1;

   assign prod1  = {16'h0, mul_a} * {16'h0, mul_b};
   assign mul_lo = prod1[15:0];
   assign mul_hi = prod1[31:16];

   mul_writeback_ctrl #(.DATA_W(DW), .REG_AW(AW), .WRITE_HI(1), .STALL_W(SW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_start(start), .i_op_a(op_a), .i_op_b(op_b),
      .i_rd_lo(rd_lo), .i_rd_hi(rd_hi),
      .o_busy(busy), .o_mul_a(mul_a), .o_mul_b(mul_b),
      .i_mul_lo(mul_lo), .i_mul_hi(mul_hi),
      .o_wr_req(wr_req), .i_wr_gnt(wr_gnt),
      .o_wr_addr(wr_addr), .o_wr_data(wr_data),
      .o_done(done), .o_ovf(ovf), .o_zero(zero),
      .o_stall_cnt(stall_cnt)
   );

   // Second instance (low word only)
   logic          start2;
   logic [DW-1:0] op_a2, op_b2;
   logic [AW-1:0] rd_lo2, rd_hi2;
   logic          busy2;
   logic [DW-1:0] mul_a2, mul_b2, mul_lo2, mul_hi2;
   logic          wr_req2, wr_gnt2;
   logic [AW-1:0] wr_addr2;
   logic [DW-1:0] wr_data2;
   logic          done2, ovf2, zero2;
   logic [SW-1:0] stall_cnt2;
   logic [31:0]   prod2;

   assign prod2   = {16'h0, mul_a2} * {16'h0, mul_b2};
   assign mul_lo2 = prod2[15:0];
   assign mul_hi2 = prod2[31:16];

   mul_writeback_ctrl #(.DATA_W(DW), .REG_AW(AW), .WRITE_HI(0), .STALL_W(SW)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .i_start(start2), .i_op_a(op_a2), .i_op_b(op_b2),
      .i_rd_lo(rd_lo2), .i_rd_hi(rd_hi2),
      .o_busy(busy2), .o_mul_a(mul_a2), .o_mul_b(mul_b2),
      .i_mul_lo(mul_lo2), .i_mul_hi(mul_hi2),
      .o_wr_req(wr_req2), .i_wr_gnt(wr_gnt2),
      .o_wr_addr(wr_addr2), .o_wr_data(wr_data2),
      .o_done(done2), .o_ovf(ovf2), .o_zero(zero2),
      .o_stall_cnt(stall_cnt2)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } wr_t;

   typedef struct {
      logic          ovf;
      logic          zero;
      logic [SW-1:0] stall;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      int            cyc;
   } dn_t;

   wr_t wq[$];
   dn_t dq[$];
   dn_t d;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_req) begin
            chk("busy_with_req", 32'(busy), 32'd1);
            if (wq.size() == 0) begin
               chk("unexpected_wr_req", 32'(wr_req), 32'd0);
            end else begin
               chk("wr_addr", 32'(wr_addr), 32'(wq[0].addr));
               chk("wr_data", 32'(wr_data), 32'(wq[0].data));
               if (wr_gnt) begin
                  chk("wr_commit_cycle", cyc, wq[0].cyc);
                  void'(wq.pop_front());
               end
            end
         end
         if (done) begin
            chk("busy_at_done", 32'(busy), 32'd0);
            if (dq.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               d = dq.pop_front();
               chk("done_cycle", cyc, d.cyc);
               chk("ovf", 32'(ovf), 32'(d.ovf));
               chk("zero", 32'(zero), 32'(d.zero));
               chk("stall_cnt", 32'(stall_cnt), 32'(d.stall));
               chk("mul_a_held", 32'(mul_a), 32'(d.a));
               chk("mul_b_held", 32'(mul_b), 32'(d.b));
            end
         end
      end
   end

   task automatic junk();
      start = 1'($urandom);
      op_a  = 16'($urandom);
      op_b  = 16'($urandom);
      rd_lo = 3'($urandom);
      rd_hi = 3'($urandom);
   endtask

   // Issues one op and drives the grant schedule; returns in the done cycle
   task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                         input int klo, input int khi);
      logic [31:0] p;
      int c0;
      int st;
      p = {16'h0, a} * {16'h0, b};
      start = 1'b1;
      op_a = a;
      op_b = b;
      rd_lo = lo;
      rd_hi = hi;
      wr_gnt = 1'($urandom);
      c0 = cyc;
      st = klo + khi;
      if (st > 255) st = 255;
      wq.push_back(wr_t'{lo, p[15:0], c0 + 2 + klo});
      wq.push_back(wr_t'{hi, p[31:16], c0 + 3 + klo + khi});
      dq.push_back(dn_t'{p[31:16] != 0, p == 0, st[7:0], a, b,
                         c0 + 4 + klo + khi});
      @(posedge clk); #1;
      junk();
      wr_gnt = 1'($urandom);
      @(posedge clk); #1;
      repeat (klo) begin
         junk();
         wr_gnt = 1'b0;
         @(posedge clk); #1;
      end
      junk();
      wr_gnt = 1'b1;
      @(posedge clk); #1;
      repeat (khi) begin
         junk();
         wr_gnt = 1'b0;
         @(posedge clk); #1;
      end
      junk();
      wr_gnt = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wr_gnt = 1'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         start = 1'b0;
         wr_gnt = 1'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_mul_a"}, 32'(mul_a), 32'd0);
      chk({tag, "_mul_b"}, 32'(mul_b), 32'd0);
      chk({tag, "_wr_req"}, 32'(wr_req), 32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
      chk({tag, "_zero"}, 32'(zero), 32'd0);
      chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0;
      logic [DW-1:0] ra, rb;
      start = 0; op_a = 0; op_b = 0; rd_lo = 0; rd_hi = 0; wr_gnt = 0;
      start2 = 0; op_a2 = 0; op_b2 = 0; rd_lo2 = 0; rd_hi2 = 0; wr_gnt2 = 0;
      #12;
      chk_all_zero("reset");
      chk("reset_busy2", 32'(busy2), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // Directed ops
      run_op(16'd3, 16'd5, 3'd1, 3'd2, 0, 0);
      idle(2);
      run_op(16'hFFFF, 16'hFFFF, 3'd4, 3'd5, 0, 0);
      idle(1);
      run_op(16'h0000, 16'h1234, 3'd6, 3'd7, 0, 0);
      idle(1);
      run_op(16'h0100, 16'h0100, 3'd3, 3'd3, 3, 0);
      run_op(16'h1234, 16'h0002, 3'd0, 3'd1, 1, 2);
      idle(1);
      run_op(16'h00FF, 16'h00FF, 3'd2, 3'd2, 200, 80);
      idle(1);

      // Randomized ops, half issued back-to-back in the done cycle
      for (int i = 0; i < 150; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 9) == 0) ra = 16'h0;
         if ($urandom_range(0, 9) == 0) rb = 16'hFFFF;
         run_op(ra, rb, 3'($urandom), 3'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(2);

      // Reset during WR_HI: no commit, no done, outputs cleared at once
      run_op_partial();
      idle(4);
      chk("wq_drained", wq.size(), 32'd0);
      chk("dq_drained", dq.size(), 32'd0);

      // Low-word-only instance: 2*3 written once, done in cycle 3
      start2 = 1'b1; op_a2 = 16'd2; op_b2 = 16'd3;
      rd_lo2 = 3'd5; rd_hi2 = 3'd6; wr_gnt2 = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      start2 = 1'b0;
      chk("w0_calc_req", 32'(wr_req2), 32'd0);
      chk("w0_calc_busy", 32'(busy2), 32'd1);
      @(posedge clk); #1;
      chk("w0_lo_cycle", cyc - c0, 32'd2);
      chk("w0_lo_req", 32'(wr_req2), 32'd1);
      chk("w0_lo_addr", 32'(wr_addr2), 32'd5);
      chk("w0_lo_data", 32'(wr_data2), 32'h6);
      chk("w0_lo_done", 32'(done2), 32'd0);
      @(posedge clk); #1;
      chk("w0_done", 32'(done2), 32'd1);
      chk("w0_done_req", 32'(wr_req2), 32'd0);
      chk("w0_done_busy", 32'(busy2), 32'd0);
      chk("w0_ovf", 32'(ovf2), 32'd0);
      chk("w0_zero", 32'(zero2), 32'd0);
      @(posedge clk); #1;
      chk("w0_done_pulse", 32'(done2), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   task automatic run_op_partial();
      start = 1'b1;
      op_a = 16'hFFFF;
      op_b = 16'hFFFF;
      rd_lo = 3'd1;
      rd_hi = 3'd2;
      wr_gnt = 1'b0;
      wq.push_back(wr_t'{3'd1, 16'h0001, cyc + 2});
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      wr_gnt = 1'b1;
      @(posedge clk); #1;
      wr_gnt = 1'b0;
      chk("pre_reset_req", 32'(wr_req), 32'd1);
      chk("pre_reset_ovf", 32'(ovf), 32'd1);
      chk("pre_reset_stall", 32'(stall_cnt), 32'd0);
      rst_n = 1'b0;
      wq.delete();
      dq.delete();
      #1;
      chk_all_zero("midop_reset");
      wr_gnt = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_held_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      wr_gnt = 1'b0;
   endtask

endmodule
